gobang_move_scheduler: RTL and testbench
========================================

# gobang_move_scheduler

Sequences the `evaluate` pattern scorer across the 15x15 board to choose the AI's next move. On `start` it walks every cell in row-major order and skips occupied cells. For each empty cell it fetches eight line-pattern codes (4 directions x attack/defense) from the pattern scanner and drives each code through `evaluate`. It accumulates the eight scores and tracks the highest-scoring cell. It sits between the game-control FSM (start/done) and the board RAM, pattern scanner and `evaluate` instance.

## Interface
- No parameters; board size fixed at 15x15 (row/col 0..14).
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when the scan completes.
- `cell_row`/`cell_col` out 4/4: board read address; also the cell being evaluated.
- `cell_occ` in 1: occupancy of the addressed cell, valid one cycle after the address (registered RAM).
- `pat_req` out 1: pattern fetch request for (`cell_row`, `cell_col`, `pat_dir`, `pat_side`).
- `pat_dir` out 2: 0=horizontal, 1=vertical, 2=diag, 3=anti-diag.
- `pat_side` out 1: 0=AI (attack), 1=human (defense).
- `pat_valid` in 1: scanner response strobe.
- `pat_state` in 3: pattern code, 0..7.
- `eval_state` out 3: registered code to `evaluate.state`.
- `eval_score` in 32: combinational score from `evaluate.score`.
- `best_row`/`best_col` out 4/4: chosen move.
- `best_score` out 32: accumulated score of the chosen move.
- `best_valid` out 1: at least one empty cell was found in the last scan.

## Operation
- States: IDLE, ADDR, OCC, REQ, EVAL, ACC, CMP, NEXT, DONE.
- IDLE: on `start` -> ADDR. Clear row/col to 0, `best_valid` to 0 and `best_score` to 0.
- ADDR: address presented -> OCC.
- OCC: if `cell_occ`=1 -> NEXT. Otherwise clear the accumulator and the lookup index k=0 -> REQ.
- Lookup index k=0..7 maps to `pat_dir`=k[1:0] and `pat_side`=k[2].
- REQ: `pat_req`=1, with address/dir/side held stable. On `pat_valid`, register `pat_state` into `eval_state`, drop `pat_req` at the next edge -> EVAL. `pat_valid` outside REQ is ignored.
- EVAL -> ACC: `eval_score` has settled.
- ACC: accumulator += score term. If k=7 -> CMP; else k++ -> REQ.
- CMP: if `best_valid`=0 or sum > `best_score` (strict), load best row/col/score and set `best_valid`=1. Ties keep the earlier cell. -> NEXT.
- NEXT: if col<14, col++. Else col=0 and row++. After (14,14) -> DONE; else -> ADDR.
- DONE: `done`=1 for one cycle -> IDLE. Best outputs hold until the next accepted `start`.
- Accumulator is 32-bit unsigned. The maximum sum is 8x2^25 = 2^28, so no overflow is possible and no saturation logic is needed.
- `start` while `busy` is ignored.
- `rst` at any point clears all state, even mid-scan.

## Timing
- Reset values:
  - `busy`, `done`, `pat_req`, `best_valid` = 0.
  - `eval_state`, `pat_dir`, `pat_side`, `cell_row`, `cell_col`, `best_row`, `best_col` = 0.
  - `best_score` = 0.
  - FSM = IDLE.
- `busy` rises the cycle after `start`. `done` and `busy` fall together on the DONE->IDLE edge.
- Occupied cell costs 3 cycles (ADDR, OCC, NEXT).
- Empty cell costs 4 + 8x(2+W) cycles, where W = cycles `pat_req` is high before `pat_valid` (W>=1). With zero-wait scanner (W=1), 28 cycles.
- `rst` asserted mid-scan: outputs hold reset values from the following edge. No `done` pulse is emitted for the aborted scan.

## Configuration
- `DEFENSE_HALF_EN` defined: defense-side terms (k=4..7) add `eval_score>>1`; attack-side terms add `eval_score` unshifted.
- Undefined: all eight terms add `eval_score` unweighted.

## Test plan
- Empty board, scanner always returns 0, W=1 -> `done` after 225x28+1 cycles from `start`; best=(0,0), `best_score`=0x00001000x8=0x00008000 is wrong for code 0. Required: `best_score`=0, `best_valid`=1, best=(0,0).
- All cells occupied -> `done` after 225x3+1 cycles; `best_valid`=0, `best_score`=0, `pat_req` never asserted.
- Only (7,7) empty, attack codes all 7, defense codes 0 -> `best_score`=0x08000000, best=(7,7).
- (3,4) and (9,2) empty, both score 0x00030000 -> tie keeps (3,4).
- Defense codes all 7, attack 0, one empty cell:
  - With `DEFENSE_HALF_EN`: `best_score`=0x04000000.
  - Without: `best_score`=0x08000000.
- `rst` pulsed during REQ with random W, then `start` re-issued -> clean full scan. No stray `done`; `pat_req` low the cycle after `rst`.

Source files
------------

// File: rtl/gobang_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gobang_move_scheduler
// Purpose  : Scans the 15x15 board and scores each empty cell from eight
//            pattern lookups. Keeps the best-scoring cell as the AI's move.
// Options  : DEFENSE_HALF_EN - defense-side terms are weighted by one half
// Revision : 1.0 - initial release
// ============================================================================
module gobang_move_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  cell_row,
  output logic [3:0]  cell_col,
  input  logic        cell_occ,
  output logic        pat_req,
  output logic [1:0]  pat_dir,
  output logic        pat_side,
  input  logic        pat_valid,
  input  logic [2:0]  pat_state,
  output logic [2:0]  eval_state,
  input  logic [31:0] eval_score,
  output logic [3:0]  best_row,
  output logic [3:0]  best_col,
  output logic [31:0] best_score,
  output logic        best_valid
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_ADDR = 4'd1,
    S_OCC  = 4'd2,
    S_REQ  = 4'd3,
    S_EVAL = 4'd4,
    S_ACC  = 4'd5,
    S_CMP  = 4'd6,
    S_NEXT = 4'd7,
    S_DONE = 4'd8
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  k;
  logic [31:0] acc;
  logic [31:0] term;
  logic        last_cell;

  assign pat_dir   = k[1:0];
  assign pat_side  = k[2];
  assign last_cell = (cell_row == 4'd14) && (cell_col == 4'd14);

`ifdef DEFENSE_HALF_EN
  assign term = k[2] ? {1'b0, eval_score[31:1]} : eval_score;
`else
  assign term = eval_score;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    pat_req   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_ADDR;
      S_ADDR: state_nxt = S_OCC;
      S_OCC:  state_nxt = cell_occ ? S_NEXT : S_REQ;
      S_REQ: begin
        pat_req = 1'b1;
        if (pat_valid) state_nxt = S_EVAL;
      end
      S_EVAL: state_nxt = S_ACC;
      S_ACC:  state_nxt = (k == 3'd7) ? S_CMP : S_REQ;
      S_CMP:  state_nxt = S_NEXT;
      S_NEXT: state_nxt = last_cell ? S_DONE : S_ADDR;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cell_row   <= 4'd0;
      cell_col   <= 4'd0;
      k          <= 3'd0;
      acc        <= 32'd0;
      eval_state <= 3'd0;
      best_row   <= 4'd0;
      best_col   <= 4'd0;
      best_score <= 32'd0;
      best_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cell_row   <= 4'd0;
          cell_col   <= 4'd0;
          best_row   <= 4'd0;
          best_col   <= 4'd0;
          best_score <= 32'd0;
          best_valid <= 1'b0;
        end
        S_OCC: if (!cell_occ) begin
          acc <= 32'd0;
          k   <= 3'd0;
        end
        S_REQ: if (pat_valid) eval_state <= pat_state;
        S_ACC: begin
          acc <= acc + term;
          if (k != 3'd7) k <= k + 3'd1;
        end
        // Strict compare: on a tie the earlier cell in scan order wins.
        S_CMP: if (!best_valid || (acc > best_score)) begin
          best_row   <= cell_row;
          best_col   <= cell_col;
          best_score <= acc;
          best_valid <= 1'b1;
        end
        S_NEXT: begin
          if (cell_col != 4'd14) begin
            cell_col <= cell_col + 4'd1;
          end else if (cell_row != 4'd14) begin
            cell_col <= 4'd0;
            cell_row <= cell_row + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gobang_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gobang_move_scheduler
// Purpose  : Directed bench with board RAM, pattern scanner and scorer models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gobang_move_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [3:0]  cell_row, cell_col;
  logic        cell_occ = 1'b0;
  logic        pat_req;
  logic [1:0]  pat_dir;
  logic        pat_side;
  logic        pat_valid;
  logic [2:0]  pat_state;
  logic [2:0]  eval_state;
  logic [31:0] eval_score;
  logic [3:0]  best_row, best_col;
  logic [31:0] best_score;
  logic        best_valid;

  int total = 0;
  int bad = 0;
  int mode = 0;
  bit rand_w = 1'b0;
  int wcnt = 0;
  int wtarget = 1;
  int done_cnt = 0;
  bit req_seen = 1'b0;
  logic occ [16][16];

  gobang_move_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .cell_row(cell_row), .cell_col(cell_col), .cell_occ(cell_occ),
    .pat_req(pat_req), .pat_dir(pat_dir), .pat_side(pat_side),
    .pat_valid(pat_valid), .pat_state(pat_state), .eval_state(eval_state),
    .eval_score(eval_score), .best_row(best_row), .best_col(best_col),
    .best_score(best_score), .best_valid(best_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] score_of(input logic [2:0] s);
    case (s)
      3'd0: return 32'h0;
      3'd1: return 32'h10;
      3'd2: return 32'h100;
      3'd3: return 32'h1000;
      3'd4: return 32'h10000;
      3'd5: return 32'h100000;
      3'd6: return 32'h1000000;
      default: return 32'h2000000;
    endcase
  endfunction

  function automatic logic [2:0] code_of(input int m, input logic [3:0] r,
                                         input logic [3:0] c, input logic [1:0] d,
                                         input logic s);
    case (m)
      1: return s ? 3'd0 : 3'd7;
      2: return (!s && d != 2'd3) ? 3'd4 : 3'd0;
      3: return s ? 3'd7 : 3'd0;
      4: return (r == 4'd10 && c == 4'd5 && d == 2'd0 && !s) ? 3'd7 : 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  assign eval_score = score_of(eval_state);
  assign pat_state  = code_of(mode, cell_row, cell_col, pat_dir, pat_side);
  assign pat_valid  = pat_req && (wcnt + 1 >= wtarget);

  // Registered board RAM and scanner wait-state model.
  always @(posedge clk) begin
    cell_occ <= occ[cell_row][cell_col];
    if (rst || !pat_req || pat_valid) begin
      wcnt <= 0;
      if (pat_valid) wtarget <= rand_w ? int'($urandom_range(1, 4)) : 1;
    end else begin
      wcnt <= wcnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
    if (pat_req) req_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        occ[r][c] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scan(input string tag, input int limit, input int mid_start, output int n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    check({tag, "_busy_rise"}, busy, 1);
    while (done !== 1'b1 && n < limit) begin
      start = (n == mid_start);
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_with_done"}, busy, 1);
    tick();
    check({tag, "_done_fall"}, done, 0);
    check({tag, "_busy_fall"}, busy, 0);
  endtask

  int n;
  int dc;

  initial begin
    fill(1'b0);
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pat_req", pat_req, 0);
    check("rst_best_valid", best_valid, 0);
    check("rst_best_score", best_score, 0);
    check("rst_addr", {cell_row, cell_col}, 0);
    check("rst_best_addr", {best_row, best_col}, 0);
    check("rst_eval_dir_side", {eval_state, pat_dir, pat_side}, 0);
    rst = 1'b0;
    tick();

    // All occupied; a start pulse mid-scan must be ignored.
    fill(1'b1);
    mode = 0;
    req_seen = 1'b0;
    run_scan("occ", 2000, 100, n);
    check("occ_cycles", n, 676);
    check("occ_best_valid", best_valid, 0);
    check("occ_best_score", best_score, 0);
    check("occ_no_req", {31'd0, req_seen}, 0);

    // Empty board, all codes zero, zero-wait scanner.
    fill(1'b0);
    mode = 0;
    run_scan("empty", 8000, 0, n);
    check("empty_cycles", n, 225 * 28 + 1);
    check("empty_best_valid", best_valid, 1);
    check("empty_best_score", best_score, 0);
    check("empty_best_addr", {best_row, best_col}, {4'd0, 4'd0});

    // Only (7,7) empty, attack codes 7.
    fill(1'b1);
    occ[7][7] = 1'b0;
    mode = 1;
    run_scan("single", 2000, 0, n);
    check("single_cycles", n, 224 * 3 + 28 + 1);
    check("single_best_score", best_score, 32'h0800_0000);
    check("single_best_addr", {best_row, best_col}, {4'd7, 4'd7});
    check("single_best_valid", best_valid, 1);

    // Two equal-score cells: the earlier one is kept.
    fill(1'b1);
    occ[3][4] = 1'b0;
    occ[9][2] = 1'b0;
    mode = 2;
    run_scan("tie", 2000, 0, n);
    check("tie_cycles", n, 223 * 3 + 2 * 28 + 1);
    check("tie_best_score", best_score, 32'h0003_0000);
    check("tie_best_addr", {best_row, best_col}, {4'd3, 4'd4});

    // Defense codes 7 on the last cell.
    fill(1'b1);
    occ[14][14] = 1'b0;
    mode = 3;
    run_scan("def", 2000, 0, n);
    check("def_best_addr", {best_row, best_col}, {4'd14, 4'd14});
`ifdef DEFENSE_HALF_EN
    check("def_best_score", best_score, 32'h0400_0000);
`else
    check("def_best_score", best_score, 32'h0800_0000);
`endif

    // Reset during a pattern request, random scanner latency.
    fill(1'b0);
    mode = 4;
    rand_w = 1'b1;
    dc = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (150) tick();
    n = 0;
    while (pat_req !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("abort_in_req", pat_req, 1);
    rst = 1'b1;
    tick();
    check("abort_pat_req", pat_req, 0);
    check("abort_busy", busy, 0);
    check("abort_best_valid", best_valid, 0);
    check("abort_best_score", best_score, 0);
    check("abort_addr", {cell_row, cell_col}, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("abort_no_done", done_cnt, dc);
    run_scan("rescan", 30000, 0, n);
    check("rescan_best_addr", {best_row, best_col}, {4'd10, 4'd5});
`ifdef DEFENSE_HALF_EN
    check("rescan_best_score", best_score, 32'h0200_0050);
`else
    check("rescan_best_score", best_score, 32'h0200_0070);
`endif
    check("rescan_best_valid", best_valid, 1);
    check("rescan_done_count", done_cnt, dc + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
